// File: rtl/music_pkg.sv
// Shared definitions for the music player: FSM encoding, octave codes,
// note word layout and the low-octave half-period table.
package music_pkg;

  localparam int unsigned CNT_W  = 14;
  localparam int unsigned NOTE_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MED  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;

  typedef struct packed {
    logic [3:0] high;
    logic [3:0] med;
    logic [3:0] low;
  } note_t;

  // Low-octave half periods in 5 MHz clocks, C4..B4; 0 for a rest.
  function automatic logic [CNT_W-1:0] low_half(input logic [2:0] digit);
    case (digit)
      3'd1:    return 14'd9555;
      3'd2:    return 14'd8513;
      3'd3:    return 14'd7584;
      3'd4:    return 14'd7159;
      3'd5:    return 14'd6378;
      3'd6:    return 14'd5682;
      3'd7:    return 14'd5062;
      default: return 14'd0;
    endcase
  endfunction

  // Each octave up halves the period.
  function automatic logic [CNT_W-1:0] half_period(input logic [2:0] digit,
                                                   input logic [1:0] octave);
    return low_half(digit) >> octave;
  endfunction

endpackage

// File: rtl/note_decode.sv
// Priority decode of a {high, med, low} note word to octave, digit,
// half-period and an invalid-digit flag. Purely combinational.
module note_decode
  import music_pkg::*;
(
  input  logic [NOTE_W-1:0] din,
  output logic [1:0]        octave_c,
  output logic [2:0]        digit_c,
  output logic [CNT_W-1:0]  half_c,
  output logic              invalid_c
);

  note_t note;

  assign note = note_t'(din);

  // First nonzero nibble from high down wins; any digit 8-15 forces a rest.
  always_comb begin
    invalid_c = note.high[3] | note.med[3] | note.low[3];
    octave_c  = OCT_LOW;
    digit_c   = 3'd0;
    if (!invalid_c) begin
      if (note.high != 4'd0) begin
        octave_c = OCT_HIGH;
        digit_c  = note.high[2:0];
      end else if (note.med != 4'd0) begin
        octave_c = OCT_MED;
        digit_c  = note.med[2:0];
      end else if (note.low != 4'd0) begin
        octave_c = OCT_LOW;
        digit_c  = note.low[2:0];
      end
    end
  end

  assign half_c = half_period(digit_c, octave_c);

endmodule

// File: rtl/tone_gen.sv
// Note-to-tone stage: latches one note word per beat and drives a square
// wave on speaker. Build option TONE_GEN_GAP_EN inserts GAP_CYCLES of
// silence before every note; without it a repeated note sustains in phase.
module tone_gen
  import music_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 50000
) (
  input  logic              clk_5m,
  input  logic              reset,
  input  logic              beat_tick,
  input  logic [NOTE_W-1:0] din,
  output logic              speaker,
  output logic              playing,
  output logic [1:0]        cur_octave,
  output logic [2:0]        cur_digit,
  output logic              err
);

  // Reject out-of-range gap lengths at elaboration.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_gap_range
    $error("tone_gen: GAP_CYCLES must be 1..65535");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               spk_nxt, playing_nxt, err_nxt;
  logic [1:0]         oct_nxt;
  logic [2:0]         dig_nxt;

`ifdef TONE_GEN_GAP_EN
  localparam int unsigned GCNT_W = 16;
  logic [GCNT_W-1:0]  gcnt, gcnt_nxt;
`endif

  logic [1:0]         dec_octave;
  logic [2:0]         dec_digit;
  logic [CNT_W-1:0]   dec_half;
  logic               dec_invalid;
  logic               dec_rest;
  logic [CNT_W-1:0]   cur_half;
  logic               keep;
  logic               restart;

  note_decode u_dec (
    .din       (din),
    .octave_c  (dec_octave),
    .digit_c   (dec_digit),
    .half_c    (dec_half),
    .invalid_c (dec_invalid)
  );

  assign dec_rest = (dec_digit == 3'd0);
  assign cur_half = half_period(cur_digit, cur_octave);

`ifdef TONE_GEN_GAP_EN
  assign keep = 1'b0;
`else
  // Same note re-struck while sounding: leave the phase alone.
  assign keep = (state == ST_PLAY) && (dec_digit == cur_digit) &&
                (dec_octave == cur_octave);
`endif

  assign restart = beat_tick && !keep;

  // State register.
  always_ff @(posedge clk_5m or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: a new word always wins, otherwise GAP times out into PLAY.
  always_comb begin
    state_nxt = state;
    case (state)
`ifdef TONE_GEN_GAP_EN
      ST_GAP:  if (gcnt == '0) state_nxt = ST_PLAY;
`endif
      ST_PLAY: state_nxt = ST_PLAY;
      ST_IDLE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (restart) begin
      if (dec_rest) begin
        state_nxt = ST_IDLE;
      end else begin
`ifdef TONE_GEN_GAP_EN
        state_nxt = ST_GAP;
`else
        state_nxt = ST_PLAY;
`endif
      end
    end
  end

  // Next values for counters, speaker and the latched status outputs.
  always_comb begin
    cnt_nxt     = cnt;
    spk_nxt     = speaker;
    oct_nxt     = cur_octave;
    dig_nxt     = cur_digit;
    err_nxt     = err | (beat_tick & dec_invalid);
    playing_nxt = (state_nxt != ST_IDLE);
`ifdef TONE_GEN_GAP_EN
    gcnt_nxt    = gcnt;
`endif
    if (beat_tick) begin
      oct_nxt = dec_octave;
      dig_nxt = dec_digit;
    end
    if (restart) begin
      spk_nxt = 1'b0;
      if (!dec_rest) begin
        cnt_nxt = dec_half - 14'd1;
`ifdef TONE_GEN_GAP_EN
        gcnt_nxt = GCNT_W'(GAP_CYCLES - 1);
`endif
      end
    end else begin
      case (state)
`ifdef TONE_GEN_GAP_EN
        ST_GAP: begin
          spk_nxt = 1'b0;
          if (gcnt == '0) cnt_nxt  = cur_half - 14'd1;
          else            gcnt_nxt = gcnt - 16'd1;
        end
`endif
        ST_PLAY: begin
          if (cnt == '0) begin
            spk_nxt = ~speaker;
            cnt_nxt = cur_half - 14'd1;
          end else begin
            cnt_nxt = cnt - 14'd1;
          end
        end
        default: spk_nxt = 1'b0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_5m or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      speaker    <= 1'b0;
      playing    <= 1'b0;
      cur_octave <= OCT_LOW;
      cur_digit  <= 3'd0;
      err        <= 1'b0;
`ifdef TONE_GEN_GAP_EN
      gcnt       <= '0;
`endif
    end else begin
      cnt        <= cnt_nxt;
      speaker    <= spk_nxt;
      playing    <= playing_nxt;
      cur_octave <= oct_nxt;
      cur_digit  <= dig_nxt;
      err        <= err_nxt;
`ifdef TONE_GEN_GAP_EN
      gcnt       <= gcnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: pitch timing, repeated-note behaviour,
// rest/invalid handling and asynchronous reset. Honours TONE_GEN_GAP_EN.
module tb_tone_gen;

`ifdef TONE_GEN_GAP_EN
  localparam int G = 100;
`else
  localparam int G = 0;
`endif

  logic        clk_5m    = 1'b0;
  logic        reset     = 1'b0;
  logic        beat_tick = 1'b0;
  logic [11:0] din       = 12'h000;
  logic        speaker;
  logic        playing;
  logic [1:0]  cur_octave;
  logic [2:0]  cur_digit;
  logic        err;

  int checks = 0;
  int errors = 0;

  tone_gen #(.GAP_CYCLES(100)) dut (
    .clk_5m     (clk_5m),
    .reset      (reset),
    .beat_tick  (beat_tick),
    .din        (din),
    .speaker    (speaker),
    .playing    (playing),
    .cur_octave (cur_octave),
    .cur_digit  (cur_digit),
    .err        (err)
  );

  always #5 clk_5m = ~clk_5m;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the tick is sampled at the next rising edge (N)
  // and control returns on the falling edge just after N.
  task automatic pulse(input logic [11:0] word);
    din       = word;
    beat_tick = 1'b1;
    @(negedge clk_5m);
    beat_tick = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_5m);
  endtask

  initial begin
    wait_n(3);
    check("rst_speaker", 16'(speaker), 16'd0);
    check("rst_playing", 16'(playing), 16'd0);
    check("rst_octave",  16'(cur_octave), 16'd0);
    check("rst_digit",   16'(cur_digit), 16'd0);
    check("rst_err",     16'(err), 16'd0);
    reset = 1'b1;
    wait_n(2);
    check("idle_playing", 16'(playing), 16'd0);

    // Med A: half 2841.
    pulse(12'h060);
    check("mA_octave",  16'(cur_octave), 16'd1);
    check("mA_digit",   16'(cur_digit), 16'd6);
    check("mA_playing", 16'(playing), 16'd1);
    check("mA_spk_n",   16'(speaker), 16'd0);
    wait_n(G + 2840);
    check("mA_spk_pre_rise", 16'(speaker), 16'd0);
    wait_n(1);
    check("mA_spk_rise", 16'(speaker), 16'd1);
    wait_n(2840);
    check("mA_spk_pre_fall", 16'(speaker), 16'd1);
    wait_n(1);
    check("mA_spk_fall", 16'(speaker), 16'd0);
    wait_n(2841);
    check("mA_spk_rise2", 16'(speaker), 16'd1);

    // Same note struck again while speaker is high.
    pulse(12'h060);
`ifdef TONE_GEN_GAP_EN
    check("rep_spk_gap", 16'(speaker), 16'd0);
    check("rep_playing", 16'(playing), 16'd1);
    wait_n(99);
    check("rep_gap_end", 16'(speaker), 16'd0);
    wait_n(2841);
    check("rep_pre_rise", 16'(speaker), 16'd0);
    wait_n(1);
    check("rep_rise", 16'(speaker), 16'd1);
`else
    check("rep_spk_cont", 16'(speaker), 16'd1);
    check("rep_digit", 16'(cur_digit), 16'd6);
    wait_n(2839);
    check("rep_pre_fall", 16'(speaker), 16'd1);
    wait_n(1);
    check("rep_fall", 16'(speaker), 16'd0);
`endif

    // High C: half 2388.
    pulse(12'h100);
    check("hC_octave", 16'(cur_octave), 16'd2);
    check("hC_digit",  16'(cur_digit), 16'd1);
    check("hC_spk_n",  16'(speaker), 16'd0);
    wait_n(G + 2387);
    check("hC_pre_rise", 16'(speaker), 16'd0);
    wait_n(1);
    check("hC_rise", 16'(speaker), 16'd1);

    // Low C: half 9555.
    pulse(12'h001);
    check("lC_octave", 16'(cur_octave), 16'd0);
    check("lC_digit",  16'(cur_digit), 16'd1);
    check("lC_spk_n",  16'(speaker), 16'd0);
    wait_n(G + 9554);
    check("lC_pre_rise", 16'(speaker), 16'd0);
    wait_n(1);
    check("lC_rise", 16'(speaker), 16'd1);

    // Rest mid-note.
    pulse(12'h000);
    check("rest_spk",     16'(speaker), 16'd0);
    check("rest_playing", 16'(playing), 16'd0);
    check("rest_digit",   16'(cur_digit), 16'd0);
    wait_n(200);
    check("rest_hold_spk", 16'(speaker), 16'd0);
    check("rest_err",      16'(err), 16'd0);

    // Invalid digit: rest plus sticky err.
    pulse(12'h090);
    check("inv_err",     16'(err), 16'd1);
    check("inv_digit",   16'(cur_digit), 16'd0);
    check("inv_playing", 16'(playing), 16'd0);
    pulse(12'h060);
    check("inv_sticky",  16'(err), 16'd1);
    check("inv_next_playing", 16'(playing), 16'd1);
    check("inv_next_digit",   16'(cur_digit), 16'd6);
    pulse(12'h802);
    check("inv_hi_digit",   16'(cur_digit), 16'd0);
    check("inv_hi_playing", 16'(playing), 16'd0);

    // Med E via priority (low nibble ignored): half 3792.
    pulse(12'h035);
    check("mE_octave", 16'(cur_octave), 16'd1);
    check("mE_digit",  16'(cur_digit), 16'd3);
    wait_n(G + 3791);
    check("mE_pre_rise", 16'(speaker), 16'd0);
    wait_n(1);
    check("mE_rise", 16'(speaker), 16'd1);
    check("mE_err_sticky", 16'(err), 16'd1);

    // Asynchronous reset while speaker is high.
    reset = 1'b0;
    #1;
    check("arst_spk",     16'(speaker), 16'd0);
    check("arst_playing", 16'(playing), 16'd0);
    check("arst_err",     16'(err), 16'd0);
    check("arst_digit",   16'(cur_digit), 16'd0);
    @(negedge clk_5m);
    din       = 12'h060;
    beat_tick = 1'b1;
    wait_n(3);
    beat_tick = 1'b0;
    check("rst_tick_ignored", 16'(playing), 16'd0);
    reset = 1'b1;
    wait_n(50);
    check("post_rst_playing", 16'(playing), 16'd0);
    check("post_rst_spk",     16'(speaker), 16'd0);
    check("post_rst_digit",   16'(cur_digit), 16'd0);

    // Resumes on the first tick after release.
    pulse(12'h001);
    check("resume_playing", 16'(playing), 16'd1);
    check("resume_digit",   16'(cur_digit), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
# tone_gen

Note-to-tone stage of the music player. It sits directly downstream of the song ROM and accepts one 12-bit note word `{high, med, low}` per beat. It decodes the word to a pitch and drives a square wave on `speaker` from the 5 MHz system clock. It also provides rest handling, an optional articulation gap and error flagging.

## Interface
Parameters:
- `GAP_CYCLES`, default 50000: silence length in clocks inserted before each note when the gap feature is built in. 10 ms at 5 MHz. Legal range is 1 to 65535.

Ports:
- `clk_5m`, input, 1 bit: system clock, 5 MHz, rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `beat_tick`, input, 1 bit: one-cycle strobe, synchronous to `clk_5m`, that marks the start of a beat.
- `din`, input, 12 bits: note word `{high[3:0], med[3:0], low[3:0]}`. Sampled only when `beat_tick` is 1.
- `speaker`, output, 1 bit: registered square-wave audio output.
- `playing`, output, 1 bit: 1 while in GAP or PLAY.
- `cur_octave`, output, 2 bits: latched octave. 0 = low, 1 = med, 2 = high.
- `cur_digit`, output, 3 bits: latched digit 1–7. 0 = rest.
- `err`, output, 1 bit: sticky flag, set when an invalid digit is seen. Cleared only by reset.

## Operation
- Digit encoding per nibble:
  - 0: unused.
  - 1–7: C D E F G A B.
  - 8–15: invalid.
- Decode priority, applied to `din` when `beat_tick` is 1:
  - First nonzero nibble of `high`, then `med`, then `low` selects the octave and digit.
  - All nibbles zero gives a rest.
  - Any nibble 8–15 gives a rest and sets `err`.
- Half-period table for the low octave, in 5 MHz clocks (C4..B4): 9555, 8513, 7584, 7159, 6378, 5682, 5062.
  - Med octave = table value >> 1.
  - High octave = table value >> 2.
  - Half-period counter is 14 bits wide.
- States: IDLE, GAP, PLAY. Reset enters IDLE.
- IDLE: `speaker` = 0, counters hold.
- On `beat_tick`, the latched octave and digit update. The next state depends on the decoded word:
  - Rest → IDLE.
  - Note, gap feature built in → GAP.
  - Note, gap feature compiled out → PLAY.
- GAP:
  - `speaker` forced to 0.
  - `gcnt` loads `GAP_CYCLES-1` on entry and counts down.
  - At `gcnt == 0`, go to PLAY and load `cnt`.
- PLAY:
  - `cnt` loads `half-1` on entry; `speaker` starts at 0.
  - Each clock: if `cnt == 0`, toggle `speaker` and reload `half-1`; otherwise decrement `cnt`.
- `beat_tick` during PLAY or GAP:
  - The new word always wins. State and counters restart as above.
  - Exception: gap feature compiled out and the new note equals the current note. Phase continues untouched with no glitch.
- `beat_tick` has no effect while `reset` is low.

## Timing
- Reset values: `speaker` = 0, `playing` = 0, `cur_octave` = 0, `cur_digit` = 0, `err` = 0, state = IDLE, `cnt` = 0, `gcnt` = 0.
- All outputs are registered and change on the `clk_5m` edge that samples `beat_tick` (edge N).
- No gap: first `speaker` rise at edge N+half. Full period is 2·half clocks.
- With gap: first rise at edge N+GAP_CYCLES+half.
- `err` asserts at edge N for an invalid word.
- Reset mid-note: `speaker` drops to 0 asynchronously. Operation resumes on the first `beat_tick` after release.
- Counters wrap only by reload; there is never a free-running wrap.

## Configuration
- Macro: `TONE_GEN_GAP_EN`.
- Defined: GAP state present. Every note, including a repeated one, is preceded by `GAP_CYCLES` of silence, so repeated notes are audibly separated.
- Undefined: GAP state, `gcnt` and `GAP_CYCLES` are unused. Notes enter PLAY directly. Identical consecutive notes sustain without a phase reset.

## Structure
- Shared package `music_pkg` holds:
  - state encoding (IDLE, GAP, PLAY);
  - octave codes;
  - the 7-entry low-octave half-period table;
  - 14-bit counter width constant.
- One natural sub-module, `note_decode`: combinational priority decode of `din` to octave, digit, half-period and invalid flag.
- Counters, FSM and `speaker` register stay in `tone_gen`.

## Test plan
- Reset release, then `beat_tick` with `din` = 0x060 (med A), gap compiled out → `speaker` rises at N+2841 and toggles every 2841 clocks. `cur_octave` = 1, `cur_digit` = 6.
- `din` = 0x100 (high C) → half-period 2388. `din` = 0x001 (low C) → half-period 9555.
- `din` = 0x000 mid-note → `speaker` = 0 and `playing` = 0 at edge N.
- `din` = 0x090 → rest, `err` = 1 and stays 1 through later valid notes until reset.
- `TONE_GEN_GAP_EN` with `GAP_CYCLES` = 100, same note repeated on two beats → `speaker` low for 100 clocks after each tick, then first rise 2841 clocks later. Without the macro, the phase is continuous across the tick.
- Assert `reset` low mid-PLAY → `speaker` = 0 immediately. Release with no `beat_tick` → remains IDLE.
